// File: rtl/bird_controller_pkg.sv
// ============================================================================
// Module   : flappy_pkg
// Purpose  : Shared game/update encodings and screen constants for the flappy
//            bird design (controller and renderer).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package flappy_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PLAYING = 2'd1,
      DEAD    = 2'd2
   } game_state_t;

   typedef enum logic [1:0] {
      WAIT  = 2'd0,
      VEL   = 2'd1,
      POS   = 2'd2,
      CHECK = 2'd3
   } update_phase_t;

   localparam int DEF_BIRD_HEIGHT       = 32;
   localparam int DEF_VER_ACTIVE_PIXELS = 720;

endpackage

`default_nettype wire

// File: rtl/bird_controller_if.sv
// ============================================================================
// Module   : bird_controller_if
// Purpose  : Frame-sync/event inputs and bird/game outputs between the pixel
//            pipeline (master) and the bird controller (slave).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface bird_controller_if
   import flappy_pkg::*;
#(
   parameter int Y_WIDTH = 10
);
   logic               vs;
   logic               flap_button;
   logic               collision;
   logic               pipe_passed;
   logic [Y_WIDTH-1:0] bird_y;
   game_state_t        game_state;
   logic [7:0]         score;
   logic               scroll_en;
   logic               update_done;

   modport master (
      output vs, flap_button, collision, pipe_passed,
      input  bird_y, game_state, score, scroll_en, update_done
   );

   modport slave (
      input  vs, flap_button, collision, pipe_passed,
      output bird_y, game_state, score, scroll_en, update_done
   );
endinterface

`default_nettype wire

// File: rtl/bird_controller_button_debouncer.sv
// ============================================================================
// Module   : button_debouncer
// Purpose  : Synchronises a raw button and emits a one-cycle pulse on each
//            debounced rising edge.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module button_debouncer #(
   parameter int DEBOUNCE_WIDTH = 20
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic btn_i,
   output logic rise_o
);
   localparam logic [DEBOUNCE_WIDTH-1:0] C_CNT_ONE = {{(DEBOUNCE_WIDTH-1){1'b0}}, 1'b1};

   logic                      sync1_q;
   logic                      sync2_q;
   logic                      level_q;
   logic                      level_d;
   logic                      rise_q;
   logic                      rise_d;
   logic [DEBOUNCE_WIDTH-1:0] cnt_q;
   logic [DEBOUNCE_WIDTH-1:0] cnt_d;

   // The level only follows the synchronised input after it has disagreed
   // for 2^DEBOUNCE_WIDTH consecutive cycles; any agreement restarts the count.
   always_comb begin
      level_d = level_q;
      rise_d  = 1'b0;
      cnt_d   = '0;
      if (sync2_q != level_q) begin
         if (&cnt_q) begin
            level_d = sync2_q;
            rise_d  = sync2_q;
         end else begin
            cnt_d = cnt_q + C_CNT_ONE;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         level_q <= 1'b0;
         rise_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= btn_i;
         sync2_q <= sync1_q;
         level_q <= level_d;
         rise_q  <= rise_d;
         cnt_q   <= cnt_d;
      end
   end

   assign rise_o = rise_q;

endmodule

`default_nettype wire

// File: rtl/bird_controller.sv
// ============================================================================
// Module   : bird_controller
// Purpose  : Per-frame bird physics and game sequencer; updates run for a few
//            cycles after each vertical-sync rise.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bird_controller
   import flappy_pkg::*;
#(
   parameter int Y_WIDTH           = 10,
   parameter int VER_ACTIVE_PIXELS = DEF_VER_ACTIVE_PIXELS,
   parameter int BIRD_HEIGHT       = DEF_BIRD_HEIGHT,
   parameter int BIRD_Y_START      = 344,
   parameter int VEL_WIDTH         = 8,
   parameter int GRAVITY           = 1,
   parameter int FLAP_VELOCITY     = -10,
   parameter int MAX_FALL_VELOCITY = 12,
   parameter int DEBOUNCE_WIDTH    = 20,
   parameter int DEAD_HOLD_FRAMES  = 60
) (
   input  logic             clk_rgb,
   input  logic             rst_n,
   bird_controller_if.slave bus
);
   localparam int DW      = $clog2(DEAD_HOLD_FRAMES + 1);
   localparam int FLOOR_Y = VER_ACTIVE_PIXELS - BIRD_HEIGHT;

   localparam logic [1:0] S_WAIT    = WAIT;
   localparam logic [1:0] S_VEL     = VEL;
   localparam logic [1:0] S_POS     = POS;
   localparam logic [1:0] S_CHECK   = CHECK;
   localparam logic [1:0] S_IDLE    = IDLE;
   localparam logic [1:0] S_PLAYING = PLAYING;
   localparam logic [1:0] S_DEAD    = DEAD;

   localparam logic [Y_WIDTH-1:0]          C_Y_START   = Y_WIDTH'(BIRD_Y_START);
   localparam logic [Y_WIDTH-1:0]          C_FLOOR_Y   = Y_WIDTH'(FLOOR_Y);
   localparam logic signed [Y_WIDTH+1:0]   C_FLOOR_EXT = (Y_WIDTH+2)'(FLOOR_Y);
   localparam logic signed [VEL_WIDTH-1:0] C_FLAP_VEL  = VEL_WIDTH'(FLAP_VELOCITY);
   localparam logic signed [VEL_WIDTH:0]   C_GRAV_EXT  = (VEL_WIDTH+1)'(GRAVITY);
   localparam logic signed [VEL_WIDTH:0]   C_MAX_EXT   = (VEL_WIDTH+1)'(MAX_FALL_VELOCITY);
   localparam logic [DW-1:0]               C_HOLD      = DW'(DEAD_HOLD_FRAMES);
   localparam logic [DW-1:0]               C_DEAD_ONE  = DW'(1);

   logic                        vs_q;
   logic                        w_frame_tick;
   logic                        w_flap_rise;
   logic [1:0]                  phase_q,        phase_d;
   logic [1:0]                  state_q,        state_d;
   logic signed [VEL_WIDTH-1:0] vel_q,          vel_d;
   logic [Y_WIDTH-1:0]          bird_y_q,       bird_y_d;
   logic [Y_WIDTH-1:0]          pos_q,          pos_d;
   logic                        floor_hit_q,    floor_hit_d;
   logic [7:0]                  score_q,        score_d;
   logic                        scroll_en_q,    scroll_en_d;
   logic                        update_done_q,  update_done_d;
   logic                        flap_pending_q, flap_pending_d;
   logic                        coll_latched_q, coll_latched_d;
   logic                        flap_take_q,    flap_take_d;
   logic                        coll_take_q,    coll_take_d;
   logic                        launch_q,       launch_d;
   logic [DW-1:0]               dead_q,         dead_d;
   logic signed [VEL_WIDTH:0]   w_vel_inc;
   logic signed [Y_WIDTH+1:0]   w_y_next;

   button_debouncer #(
      .DEBOUNCE_WIDTH (DEBOUNCE_WIDTH)
   ) u_debouncer (
      .clk_i  (clk_rgb),
      .rst_ni (rst_n),
      .btn_i  (bus.flap_button),
      .rise_o (w_flap_rise)
   );

   assign w_frame_tick = bus.vs & ~vs_q;
   assign w_vel_inc    = $signed({vel_q[VEL_WIDTH-1], vel_q}) + C_GRAV_EXT;
   assign w_y_next     = $signed({2'b00, bird_y_q})
                       + $signed({{(Y_WIDTH+2-VEL_WIDTH){vel_q[VEL_WIDTH-1]}}, vel_q});

   always_comb begin
      phase_d        = phase_q;
      state_d        = state_q;
      vel_d          = vel_q;
      bird_y_d       = bird_y_q;
      pos_d          = pos_q;
      floor_hit_d    = floor_hit_q;
      score_d        = score_q;
      dead_d         = dead_q;
      launch_d       = launch_q;
      flap_take_d    = flap_take_q;
      coll_take_d    = coll_take_q;
      flap_pending_d = flap_pending_q | w_flap_rise;
      coll_latched_d = coll_latched_q | bus.collision;
      update_done_d  = 1'b0;

      if (state_q == S_PLAYING && bus.pipe_passed && score_q != 8'hFF) begin
         score_d = score_q + 8'd1;
      end

      case (phase_q)
         S_WAIT: begin
            // Events are handed to this update at the tick; anything arriving
            // while the update runs stays pending for the next frame.
            if (w_frame_tick) begin
               phase_d        = S_VEL;
               flap_take_d    = flap_pending_q;
               coll_take_d    = coll_latched_q;
               flap_pending_d = w_flap_rise;
               coll_latched_d = bus.collision;
            end
         end
         S_VEL: begin
            phase_d  = S_POS;
            launch_d = 1'b0;
            if (state_q == S_IDLE) begin
               vel_d = '0;
            end else if (state_q == S_PLAYING && (flap_take_q || launch_q)) begin
               vel_d = C_FLAP_VEL;
            end else if (w_vel_inc > C_MAX_EXT) begin
               vel_d = C_MAX_EXT[VEL_WIDTH-1:0];
            end else begin
               vel_d = w_vel_inc[VEL_WIDTH-1:0];
            end
         end
         S_POS: begin
            phase_d     = S_CHECK;
            floor_hit_d = 1'b0;
            if (w_y_next[Y_WIDTH+1]) begin
               pos_d = '0;
               vel_d = '0;
            end else if (w_y_next >= C_FLOOR_EXT) begin
               pos_d       = C_FLOOR_Y;
               floor_hit_d = 1'b1;
            end else begin
               pos_d = w_y_next[Y_WIDTH-1:0];
            end
         end
         S_CHECK: begin
            phase_d       = S_WAIT;
            update_done_d = 1'b1;
            bird_y_d      = pos_q;
            case (state_q)
               S_IDLE: begin
                  if (flap_take_q) begin
                     state_d  = S_PLAYING;
                     score_d  = '0;
                     launch_d = 1'b1;
                  end
               end
               S_PLAYING: begin
                  if (coll_take_q || floor_hit_q) begin
                     state_d = S_DEAD;
                     dead_d  = '0;
                  end
               end
               S_DEAD: begin
                  if (flap_take_q && dead_q == C_HOLD) begin
                     state_d  = S_IDLE;
                     bird_y_d = C_Y_START;
                     vel_d    = '0;
                  end else if (dead_q != C_HOLD) begin
                     dead_d = dead_q + C_DEAD_ONE;
                  end
               end
               default: state_d = S_IDLE;
            endcase
         end
         default: phase_d = S_WAIT;
      endcase

      scroll_en_d = (state_d == S_PLAYING);
   end

   // vs_q resets high so a vs already asserted at reset release is not a rise.
   always_ff @(posedge clk_rgb or negedge rst_n) begin
      if (!rst_n) begin
         vs_q           <= 1'b1;
         phase_q        <= S_WAIT;
         state_q        <= S_IDLE;
         vel_q          <= '0;
         bird_y_q       <= C_Y_START;
         pos_q          <= C_Y_START;
         floor_hit_q    <= 1'b0;
         score_q        <= '0;
         scroll_en_q    <= 1'b0;
         update_done_q  <= 1'b0;
         flap_pending_q <= 1'b0;
         coll_latched_q <= 1'b0;
         flap_take_q    <= 1'b0;
         coll_take_q    <= 1'b0;
         launch_q       <= 1'b0;
         dead_q         <= '0;
      end else begin
         vs_q           <= bus.vs;
         phase_q        <= phase_d;
         state_q        <= state_d;
         vel_q          <= vel_d;
         bird_y_q       <= bird_y_d;
         pos_q          <= pos_d;
         floor_hit_q    <= floor_hit_d;
         score_q        <= score_d;
         scroll_en_q    <= scroll_en_d;
         update_done_q  <= update_done_d;
         flap_pending_q <= flap_pending_d;
         coll_latched_q <= coll_latched_d;
         flap_take_q    <= flap_take_d;
         coll_take_q    <= coll_take_d;
         launch_q       <= launch_d;
         dead_q         <= dead_d;
      end
   end

   assign bus.bird_y      = bird_y_q;
   assign bus.game_state  = game_state_t'(state_q);
   assign bus.score       = score_q;
   assign bus.scroll_en   = scroll_en_q;
   assign bus.update_done = update_done_q;

endmodule

`default_nettype wire

// File: tb/tb_bird_controller.sv
// ============================================================================
// Module   : tb_bird_controller
// Purpose  : Frame-level random/directed bench for bird_controller against a
//            per-frame game model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bird_controller;
   localparam int MS_IDLE = 0;
   localparam int MS_PLAY = 1;
   localparam int MS_DEAD = 2;

   logic clk_rgb = 1'b0;
   logic rst_n;

   bird_controller_if #(.Y_WIDTH(10)) bus ();

   bird_controller #(
      .DEBOUNCE_WIDTH (4)
   ) dut (
      .clk_rgb (clk_rgb),
      .rst_n   (rst_n),
      .bus     (bus)
   );

   always #5 clk_rgb = ~clk_rgb;

   int n_vec = 0;
   int n_err = 0;

   int m_state, m_y, m_vel, m_score, m_dead;
   bit m_flap, m_coll, m_launch;

   task automatic chk(input string tag, input int obs, input int exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_state = MS_IDLE; m_y = 344; m_vel = 0; m_score = 0; m_dead = 0;
      m_flap = 0; m_coll = 0; m_launch = 0;
   endtask

   task automatic model_score_pulse();
      if (m_state == MS_PLAY && m_score < 255) m_score++;
   endtask

   // One frame of game rules, applied at the vertical-sync rise.
   task automatic model_frame();
      bit flap, coll, floor_hit;
      int y;
      flap = m_flap; coll = m_coll;
      m_flap = 0; m_coll = 0;
      if (m_state == MS_IDLE)                        m_vel = 0;
      else if (m_state == MS_PLAY && (flap || m_launch)) m_vel = -10;
      else                                           m_vel = (m_vel + 1 > 12) ? 12 : m_vel + 1;
      m_launch = 0;
      y = m_y + m_vel;
      floor_hit = 0;
      if (y < 0) begin
         y = 0; m_vel = 0;
      end else if (y >= 688) begin
         y = 688; floor_hit = 1;
      end
      m_y = y;
      if (m_state == MS_IDLE) begin
         if (flap) begin m_state = MS_PLAY; m_score = 0; m_launch = 1; end
      end else if (m_state == MS_PLAY) begin
         if (coll || floor_hit) begin m_state = MS_DEAD; m_dead = 0; end
      end else begin
         if (flap && m_dead == 60) begin
            m_state = MS_IDLE; m_y = 344; m_vel = 0;
         end else if (m_dead < 60) begin
            m_dead++;
         end
      end
   endtask

   task automatic check_outputs(input string where);
      chk({where, "_state"},  int'(bus.game_state), m_state);
      chk({where, "_y"},      int'(bus.bird_y),     m_y);
      chk({where, "_score"},  int'(bus.score),      m_score);
      chk({where, "_scroll"}, int'(bus.scroll_en),  (m_state == MS_PLAY) ? 1 : 0);
   endtask

   task automatic tick();
      @(posedge clk_rgb); #1;
   endtask

   task automatic do_frame(input int presses, input bit coll, input int npipe,
                           input bit pipe_chk, input bit glitch);
      int  n;
      bit  seen;
      int  st_before;
      st_before = m_state;
      tick();
      bus.vs = 1'b1;
      seen = 0; n = 0;
      while (!seen && n < 10) begin
         tick();
         n++;
         bus.pipe_passed = (n == 3 && pipe_chk);
         if (bus.update_done) seen = 1;
      end
      bus.pipe_passed = 1'b0;
      chk("latency", seen ? n - 1 : -1, 3);
      if (pipe_chk && st_before == MS_PLAY && m_score < 255) m_score++;
      model_frame();
      check_outputs("upd");
      tick();
      chk("done_pulse_len", int'(bus.update_done), 0);
      bus.vs = 1'b0;
      for (int i = 0; i < npipe; i++) begin
         bus.pipe_passed = 1'b1; tick();
         model_score_pulse();
         bus.pipe_passed = 1'b0; tick();
      end
      if (coll) begin
         bus.collision = 1'b1; tick();
         bus.collision = 1'b0; m_coll = 1;
      end
      if (glitch) begin
         bus.flap_button = 1'b1; repeat (5) tick();
         bus.flap_button = 1'b0; repeat (24) tick();
      end
      for (int p = 0; p < presses; p++) begin
         bus.flap_button = 1'b1; repeat (24) tick();
         bus.flap_button = 1'b0; repeat (24) tick();
         m_flap = 1;
      end
      repeat (4) tick();
      chk("active_state_hold", int'(bus.game_state), m_state);
      chk("active_y_hold",     int'(bus.bird_y),     m_y);
   endtask

   task automatic dead_until_idle();
      for (int i = 0; i < 90 && m_state == MS_DEAD; i++)
         do_frame((m_dead == 10 || m_dead == 60) ? 1 : 0, 1'b0, 1, 1'b0, 1'b0);
      chk("dead_exit_state", int'(bus.game_state), MS_IDLE);
      chk("dead_exit_y",     int'(bus.bird_y),     344);
   endtask

   initial begin
      int cnt;
      bus.vs = 1'b1; bus.flap_button = 1'b0; bus.collision = 1'b0; bus.pipe_passed = 1'b0;
      rst_n = 1'b0;
      model_reset();
      repeat (3) tick();
      check_outputs("reset");
      chk("reset_done", int'(bus.update_done), 0);
      rst_n = 1'b1;
      cnt = 0;
      repeat (10) begin
         tick();
         if (bus.update_done) cnt++;
      end
      chk("no_tick_vs_high", cnt, 0);
      bus.vs = 1'b0;
      repeat (3) tick();

      repeat (3) do_frame(0, 1'b0, 0, 1'b0, 1'b0);
      do_frame(0, 1'b0, 0, 1'b0, 1'b1);
      do_frame(0, 1'b0, 0, 1'b0, 1'b0);
      chk("glitch_idle", int'(bus.game_state), MS_IDLE);

      do_frame(2, 1'b0, 0, 1'b0, 1'b0);
      do_frame(0, 1'b0, 0, 1'b0, 1'b0);
      chk("start_playing", int'(bus.game_state), MS_PLAY);
      do_frame(0, 1'b0, 0, 1'b0, 1'b0);
      chk("flap_y1", int'(bus.bird_y), 334);
      do_frame(0, 1'b0, 0, 1'b0, 1'b0);
      chk("flap_y2", int'(bus.bird_y), 325);
      do_frame(0, 1'b0, 0, 1'b0, 1'b0);
      chk("flap_y3", int'(bus.bird_y), 317);

      for (int i = 0; i < 60 && m_state == MS_PLAY; i++)
         do_frame(0, 1'b0, (i % 3 == 0) ? 1 : 0, 1'b0, 1'b0);
      chk("floor_y",     int'(bus.bird_y),     688);
      chk("floor_dead",  int'(bus.game_state), MS_DEAD);
      chk("floor_noscr", int'(bus.scroll_en),  0);
      dead_until_idle();

      do_frame(1, 1'b0, 0, 1'b0, 1'b0);
      do_frame(0, 1'b0, 0, 1'b0, 1'b0);
      chk("restart_score", int'(bus.score), 0);
      do_frame(1, 1'b1, 2, 1'b0, 1'b0);
      do_frame(0, 1'b0, 0, 1'b1, 1'b0);
      chk("death_wins",     int'(bus.game_state), MS_DEAD);
      chk("score_at_death", int'(bus.score),      3);
      dead_until_idle();

      do_frame(1, 1'b0, 0, 1'b0, 1'b0);
      do_frame(0, 1'b0, 260, 1'b0, 1'b0);
      chk("score_sat", int'(bus.score), 255);

      tick();
      bus.vs = 1'b1;
      tick();
      tick();
      rst_n = 1'b0;
      #1;
      model_reset();
      check_outputs("rst_mid_pos");
      chk("rst_mid_done", int'(bus.update_done), 0);
      bus.vs = 1'b0;
      repeat (2) tick();
      rst_n = 1'b1;
      repeat (3) tick();

      for (int f = 0; f < 150; f++) begin
         do_frame(($urandom_range(0, 3) == 0) ? 1 : 0,
                  ($urandom_range(0, 7) == 0),
                  $urandom_range(0, 3),
                  ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 9) == 0));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule

`default_nettype wire
